xcfi_check_scheduler: RTL and testbench

XCFI_CHECK_SCHEDULER -- requirements
Module: xcfi_check_scheduler

---
 rtl/xcfi_check_scheduler_if.sv | 35 +++
 rtl/xcfi_check_scheduler.sv | 99 +++++++++
 tb/tb_xcfi_check_scheduler.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/xcfi_check_scheduler_if.sv
// Interface bundling the retirement (RVFI) inputs and the scheduler status
// outputs of xcfi_check_scheduler.
//   master : retirement source / observer (drives rvfi_*, reads status)
//   slave  : the scheduler itself (reads rvfi_*, drives status)
// Signals:
//   rvfi_valid  - an instruction retires this cycle
//   rvfi_order  - order number of the retiring instruction
//   rvfi_halt   - the retiring instruction halts the core
//   check       - one-cycle check strobe
//   check_order - rvfi_order captured when check fired
//   armed/done/timeout/halted - status flags
//   cycle/retired - saturating cycle and retirement counters
interface xcfi_check_scheduler_if;
    logic        rvfi_valid;
    logic [63:0] rvfi_order;
    logic        rvfi_halt;
    logic        check;
    logic [63:0] check_order;
    logic        armed;
    logic        done;
    logic        timeout;
    logic        halted;
    logic [7:0]  cycle;
    logic [7:0]  retired;

    modport master (
        output rvfi_valid, rvfi_order, rvfi_halt,
        input  check, check_order, armed, done, timeout, halted, cycle, retired
    );

    modport slave (
        input  rvfi_valid, rvfi_order, rvfi_halt,
        output check, check_order, armed, done, timeout, halted, cycle, retired
    );
endinterface

// File: rtl/xcfi_check_scheduler.sv
// Schedules a single formal-style check on a retiring instruction inside a
// cycle window [CHECK_CYCLE, TIMEOUT_CYCLE], once at least MIN_RETIRE
// retirements (including the checked one) have been seen.
// Ports:
//   clock - rising-edge clock
//   reset - asynchronous active-high reset
//   bus   - xcfi_check_scheduler_if.slave (RVFI inputs, status outputs)
module xcfi_check_scheduler #(
    parameter int unsigned CHECK_CYCLE   = 15,
    parameter int unsigned MIN_RETIRE    = 1,
    parameter int unsigned TIMEOUT_CYCLE = 40
) (
    input  logic                   clock,
    input  logic                   reset,
    xcfi_check_scheduler_if.slave  bus
);

    if (CHECK_CYCLE < 2 || CHECK_CYCLE >= TIMEOUT_CYCLE || TIMEOUT_CYCLE > 254 ||
        MIN_RETIRE < 1 || MIN_RETIRE > 255) begin : g_bad_params
        $error("xcfi_check_scheduler: illegal parameter combination");
    end

    localparam logic [7:0] ARM_AT     = 8'(CHECK_CYCLE - 1);
    localparam logic [7:0] TIMEOUT_AT = 8'(TIMEOUT_CYCLE);
    localparam logic [8:0] MIN_RET9   = 9'(MIN_RETIRE);

    typedef enum logic [2:0] {
        WARMUP,
        ARMED,
        DONE,
        TIMEOUT,
        HALTED
    } state_t;

    state_t      state, state_nx;
    logic [7:0]  cycle_q;
    logic [7:0]  retired_q;
    logic [63:0] check_order_q;
    logic        halted_q;
    logic        check_w;
    logic        halt_ret;

    assign halt_ret = bus.rvfi_valid && bus.rvfi_halt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= WARMUP;
            cycle_q       <= 8'd1;
            retired_q     <= '0;
            check_order_q <= '0;
            halted_q      <= 1'b0;
        end else begin
            state <= state_nx;
            if (cycle_q != 8'hFF)
                cycle_q <= cycle_q + 8'd1;
            if (bus.rvfi_valid && retired_q != 8'hFF)
                retired_q <= retired_q + 8'd1;
            if (check_w)
                check_order_q <= bus.rvfi_order;
            if (halt_ret)
                halted_q <= 1'b1;
        end
    end

    always_comb begin
        state_nx = state;
        // retired+1 at 9 bits so a saturated counter still compares correctly
        check_w  = (state == ARMED) && bus.rvfi_valid &&
                   (({1'b0, retired_q} + 9'd1) >= MIN_RET9);
        case (state)
            WARMUP: begin
                if (halt_ret)
                    state_nx = HALTED;
                else if (cycle_q == ARM_AT)
                    state_nx = ARMED;
            end
            ARMED: begin
                // check beats both halt and timeout
                if (check_w)
                    state_nx = DONE;
                else if (halt_ret)
                    state_nx = HALTED;
                else if (cycle_q == TIMEOUT_AT)
                    state_nx = TIMEOUT;
            end
            default: state_nx = state;
        endcase
    end

    assign bus.check       = check_w;
    assign bus.check_order = check_order_q;
    assign bus.armed       = (state == ARMED);
    assign bus.done        = (state == DONE) || (state == TIMEOUT) || (state == HALTED);
    assign bus.timeout     = (state == TIMEOUT);
    assign bus.halted      = halted_q;
    assign bus.cycle       = cycle_q;
    assign bus.retired     = retired_q;

endmodule

// File: tb/tb_xcfi_check_scheduler.sv
// Bench for xcfi_check_scheduler: one default instance and one with
// MIN_RETIRE=3 share the same stimulus; expected check events are queued
// per instance and matched against the observed check strobes.
module tb_xcfi_check_scheduler;

    typedef struct {
        int unsigned cyc;
        logic [63:0] ord;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        v     = 1'b0;
    logic        h     = 1'b0;
    logic [63:0] ord   = '0;

    int unsigned tcyc  = 1;
    int unsigned total = 0;
    int unsigned bad   = 0;

    exp_t q0[$];
    exp_t q3[$];

    xcfi_check_scheduler_if if0 ();
    xcfi_check_scheduler_if if3 ();

    assign if0.rvfi_valid = v;
    assign if0.rvfi_order = ord;
    assign if0.rvfi_halt  = h;
    assign if3.rvfi_valid = v;
    assign if3.rvfi_order = ord;
    assign if3.rvfi_halt  = h;

    xcfi_check_scheduler u_dut0 (
        .clock (clock),
        .reset (reset),
        .bus   (if0)
    );

    xcfi_check_scheduler #(
        .MIN_RETIRE (3)
    ) u_dut3 (
        .clock (clock),
        .reset (reset),
        .bus   (if3)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic reset_vals(input string tag);
        check_eq({tag, " cycle"},       64'(if0.cycle),   64'd1);
        check_eq({tag, " retired"},     64'(if0.retired), 64'd0);
        check_eq({tag, " check_order"}, if0.check_order,  64'd0);
        check_eq({tag, " check_order3"}, if3.check_order, 64'd0);
        check_eq({tag, " halted"},      64'(if0.halted),  64'd0);
        check_eq({tag, " check"},       64'(if0.check),   64'd0);
        check_eq({tag, " check3"},      64'(if3.check),   64'd0);
        check_eq({tag, " armed"},       64'(if0.armed),   64'd0);
        check_eq({tag, " done"},        64'(if0.done),    64'd0);
        check_eq({tag, " timeout"},     64'(if0.timeout), 64'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        v = 1'b0; h = 1'b0; ord = '0;
        q0.delete();
        q3.delete();
        repeat (2) @(posedge clock);
        #1;
        reset_vals("rst");
        reset = 1'b0;
        tcyc  = 1;
    endtask

    // One clock cycle: drive inputs for cycle tcyc, compare the check strobes
    // against the scoreboard at the falling edge, then check_order after the edge.
    task automatic step(input logic vi, input logic [63:0] oi, input logic hi);
        logic  fire0, fire3;
        exp_t  e0, e3;
        v = vi; ord = oi; h = hi;
        @(negedge clock);
        check_eq("cycle", 64'(if0.cycle), 64'(tcyc > 255 ? 255 : tcyc));
        fire0 = (q0.size() != 0) && (q0[0].cyc == tcyc);
        fire3 = (q3.size() != 0) && (q3[0].cyc == tcyc);
        check_eq("dut0 check", 64'(if0.check), 64'(fire0));
        check_eq("dut3 check", 64'(if3.check), 64'(fire3));
        if (fire0) e0 = q0.pop_front();
        if (fire3) e3 = q3.pop_front();
        @(posedge clock);
        #1;
        tcyc++;
        if (fire0) check_eq("dut0 check_order", if0.check_order, e0.ord);
        if (fire3) check_eq("dut3 check_order", if3.check_order, e3.ord);
    endtask

    task automatic drained(input string tag);
        check_eq({tag, " q0 drained"}, 64'(q0.size()), 64'd0);
        check_eq({tag, " q3 drained"}, 64'(q3.size()), 64'd0);
    endtask

    task automatic run_s1(input string tag);
        q0.push_back('{15, 64'd15});
        q3.push_back('{15, 64'd15});
        for (int unsigned c = 1; c <= 260; c++) begin
            step(1'b1, 64'(c), 1'b0);
            if (tcyc == 14) check_eq({tag, " armed early"}, 64'(if0.armed), 64'd0);
            if (tcyc == 15) begin
                check_eq({tag, " armed@15"},  64'(if0.armed), 64'd1);
                check_eq({tag, " armed3@15"}, 64'(if3.armed), 64'd1);
            end
            if (tcyc == 16) begin
                check_eq({tag, " done@16"},    64'(if0.done),    64'd1);
                check_eq({tag, " done3@16"},   64'(if3.done),    64'd1);
                check_eq({tag, " armed@16"},   64'(if0.armed),   64'd0);
                check_eq({tag, " timeout@16"}, 64'(if0.timeout), 64'd0);
            end
        end
        check_eq({tag, " retired sat"},  64'(if0.retired), 64'd255);
        check_eq({tag, " cycle sat"},    64'(if0.cycle),   64'd255);
        check_eq({tag, " order held"},   if0.check_order,  64'd15);
        check_eq({tag, " order3 held"},  if3.check_order,  64'd15);
        check_eq({tag, " timeout end"},  64'(if0.timeout), 64'd0);
        drained(tag);
    endtask

    initial begin
        // valid every cycle, order = cycle
        do_reset();
        run_s1("s1");

        // single retirement at cycle 22, order 7
        do_reset();
        q0.push_back('{22, 64'd7});
        for (int unsigned c = 1; c <= 45; c++) begin
            step(c == 22, (c == 22) ? 64'd7 : 64'd0, 1'b0);
            if (tcyc == 23) begin
                check_eq("s2 done@23",    64'(if0.done),    64'd1);
                check_eq("s2 timeout@23", 64'(if0.timeout), 64'd0);
                check_eq("s2 order",      if0.check_order,  64'd7);
            end
            if (tcyc == 41) check_eq("s2 dut3 timeout@41", 64'(if3.timeout), 64'd1);
        end
        check_eq("s2 timeout end", 64'(if0.timeout), 64'd0);
        drained("s2");

        // no retirement -> timeout
        do_reset();
        for (int unsigned c = 1; c <= 45; c++) begin
            step(1'b0, 64'd0, 1'b0);
            if (tcyc == 40) begin
                check_eq("s3 armed@40",   64'(if0.armed),   64'd1);
                check_eq("s3 timeout@40", 64'(if0.timeout), 64'd0);
                check_eq("s3 done@40",    64'(if0.done),    64'd0);
            end
            if (tcyc == 41) begin
                check_eq("s3 timeout@41", 64'(if0.timeout), 64'd1);
                check_eq("s3 done@41",    64'(if0.done),    64'd1);
                check_eq("s3 armed@41",   64'(if0.armed),   64'd0);
            end
        end
        drained("s3");

        // halt at cycle 10 (warmup)
        do_reset();
        for (int unsigned c = 1; c <= 45; c++) begin
            step(c == 10, 64'(c), c == 10);
            if (tcyc == 10) check_eq("s4a halted@10", 64'(if0.halted), 64'd0);
            if (tcyc == 11) begin
                check_eq("s4a halted@11", 64'(if0.halted), 64'd1);
                check_eq("s4a done@11",   64'(if0.done),   64'd1);
                check_eq("s4a armed@11",  64'(if0.armed),  64'd0);
            end
        end
        check_eq("s4a timeout end", 64'(if0.timeout), 64'd0);
        check_eq("s4a armed end",   64'(if0.armed),   64'd0);
        drained("s4a");

        // halt at cycle 15: check wins on dut0, dut3 halts without check
        do_reset();
        q0.push_back('{15, 64'd15});
        for (int unsigned c = 1; c <= 45; c++) begin
            step(c == 15, 64'(c), c == 15);
            if (tcyc == 16) begin
                check_eq("s4b done@16",     64'(if0.done),    64'd1);
                check_eq("s4b halted@16",   64'(if0.halted),  64'd1);
                check_eq("s4b timeout@16",  64'(if0.timeout), 64'd0);
                check_eq("s4b dut3 halted", 64'(if3.halted),  64'd1);
                check_eq("s4b dut3 done",   64'(if3.done),    64'd1);
                check_eq("s4b dut3 order",  if3.check_order,  64'd0);
            end
        end
        check_eq("s4b timeout end",  64'(if0.timeout), 64'd0);
        check_eq("s4b timeout3 end", 64'(if3.timeout), 64'd0);
        drained("s4b");

        // retirements at 16,17,18: dut3 needs three
        do_reset();
        q0.push_back('{16, 64'd16});
        q3.push_back('{18, 64'd18});
        for (int unsigned c = 1; c <= 45; c++) begin
            step(c >= 16 && c <= 18, 64'(c), 1'b0);
            if (tcyc == 18) check_eq("s5 dut3 armed@18", 64'(if3.armed), 64'd1);
            if (tcyc == 19) begin
                check_eq("s5 dut3 retired@19", 64'(if3.retired), 64'd3);
                check_eq("s5 dut3 done@19",    64'(if3.done),    64'd1);
            end
        end
        drained("s5");

        // asynchronous reset during cycle 15 with a retirement pending
        do_reset();
        for (int unsigned c = 1; c <= 14; c++) step(1'b1, 64'(c), 1'b0);
        check_eq("s6 armed before", 64'(if0.armed), 64'd1);
        v = 1'b1; ord = 64'd15; h = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        reset_vals("s6 async");
        @(posedge clock);
        #1;
        reset_vals("s6 held");
        reset = 1'b0;
        tcyc  = 1;
        run_s1("s6 rerun");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
